// File: rtl/axi4_id_compressor.sv
// Wide-to-narrow AXI4 ID translation for one DDR channel.
// Each in-flight wide ID owns a table slot, and the slot index is issued as the narrow ID.
module axi4_id_compressor #(
    parameter int unsigned IN_ID_W   = 16,
    parameter int unsigned OUT_ID_W  = 6,
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned AX_PW     = 64,
    parameter int unsigned R_PW      = 515,
    parameter int unsigned B_PW      = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    // AR
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [IN_ID_W-1:0]  s_arid,
    input  logic [AX_PW-1:0]    s_ar_pl,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [OUT_ID_W-1:0] m_arid,
    output logic [AX_PW-1:0]    m_ar_pl,
    // AW
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [IN_ID_W-1:0]  s_awid,
    input  logic [AX_PW-1:0]    s_aw_pl,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [OUT_ID_W-1:0] m_awid,
    output logic [AX_PW-1:0]    m_aw_pl,
    // R
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [OUT_ID_W-1:0] m_rid,
    input  logic [R_PW-1:0]     m_r_pl,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [IN_ID_W-1:0]  s_rid,
    output logic [R_PW-1:0]     s_r_pl,
    // B
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [OUT_ID_W-1:0] m_bid,
    input  logic [B_PW-1:0]     m_b_pl,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [IN_ID_W-1:0]  s_bid,
    output logic [B_PW-1:0]     s_b_pl,
    output logic                err_resp
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Direction index: 0 = read (AR/R), 1 = write (AW/B)
    logic [1:0]          w_ax_svalid, w_ax_sready, w_ax_mready, w_ax_full;
    logic [IN_ID_W-1:0]  w_ax_sid  [2];
    logic [AX_PW-1:0]    w_ax_spl  [2];
    logic [OUT_ID_W-1:0] w_ax_mid  [2];
    logic [AX_PW-1:0]    w_ax_mpl  [2];
    logic [1:0]          w_rsp_mvalid, w_rsp_sready, w_rsp_last, w_err_c;
    logic [OUT_ID_W-1:0] w_rsp_mid [2];
    logic [IN_ID_W-1:0]  w_rsp_sid [2];
    logic                r_err;

    assign w_ax_svalid  = {s_awvalid, s_arvalid};
    assign w_ax_mready  = {m_awready, m_arready};
    assign w_ax_sid[0]  = s_arid;
    assign w_ax_sid[1]  = s_awid;
    assign w_ax_spl[0]  = s_ar_pl;
    assign w_ax_spl[1]  = s_aw_pl;
    assign w_rsp_mvalid = {m_bvalid, m_rvalid};
    assign w_rsp_sready = {s_bready, s_rready};
    // Every B beat ends its transaction
    assign w_rsp_last   = {1'b1, m_r_pl[0]};
    assign w_rsp_mid[0] = m_rid;
    assign w_rsp_mid[1] = m_bid;

    assign s_arready = w_ax_sready[0];
    assign m_arvalid = w_ax_full[0];
    assign m_arid    = w_ax_mid[0];
    assign m_ar_pl   = w_ax_mpl[0];
    assign s_awready = w_ax_sready[1];
    assign m_awvalid = w_ax_full[1];
    assign m_awid    = w_ax_mid[1];
    assign m_aw_pl   = w_ax_mpl[1];

    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;
    assign s_r_pl    = m_r_pl;
    assign s_rid     = w_rsp_sid[0];
    assign s_bvalid  = m_bvalid;
    assign m_bready  = s_bready;
    assign s_b_pl    = m_b_pl;
    assign s_bid     = w_rsp_sid[1];
    assign err_resp  = r_err;

    for (genvar g = 0; g < 2; g++) begin : g_dir
        logic [NUM_SLOTS-1:0] r_valid;
        logic [IN_ID_W-1:0]   r_id  [NUM_SLOTS];
        logic [CNT_W-1:0]     r_cnt [NUM_SLOTS];
        logic                 r_full;
        logic [OUT_ID_W-1:0]  r_mid;
        logic [AX_PW-1:0]     r_pl;
        logic                 w_hit, w_free, w_slot_ok, w_issue, w_release, w_rsp_ok;
        logic [IDX_W-1:0]     w_hit_idx, w_free_idx, w_sel_idx, w_rsp_idx;
        logic [NUM_SLOTS-1:0] w_inc, w_dec;

        // Table lookup: matching valid slot, else lowest free slot
        always_comb begin
            w_hit      = 1'b0;
            w_hit_idx  = '0;
            w_free     = 1'b0;
            w_free_idx = '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (r_valid[i] && (r_id[i] == w_ax_sid[g])) begin
                    w_hit     = 1'b1;
                    w_hit_idx = IDX_W'(i);
                end
                if (!r_valid[i] && !w_free) begin
                    w_free     = 1'b1;
                    w_free_idx = IDX_W'(i);
                end
            end
        end

        assign w_sel_idx      = w_hit ? w_hit_idx : w_free_idx;
        assign w_slot_ok      = w_hit ? (r_cnt[w_hit_idx] != CNT_MAX) : w_free;
        assign w_ax_sready[g] = w_slot_ok && (!r_full || w_ax_mready[g]);
        assign w_issue        = w_ax_svalid[g] && w_ax_sready[g];

        // Response side: restore the wide ID, flag unknown narrow IDs
        assign w_rsp_idx    = w_rsp_mid[g][IDX_W-1:0];
        assign w_rsp_ok     = (32'(w_rsp_mid[g]) < NUM_SLOTS) && r_valid[w_rsp_idx];
        assign w_release    = w_rsp_mvalid[g] && w_rsp_sready[g] && w_rsp_last[g] && w_rsp_ok;
        assign w_rsp_sid[g] = w_rsp_ok ? r_id[w_rsp_idx] : '0;
        assign w_err_c[g]   = w_rsp_mvalid[g] && !w_rsp_ok;

        always_comb begin
            w_inc = '0;
            w_dec = '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                w_inc[i] = w_issue && (w_sel_idx == IDX_W'(i));
                w_dec[i] = w_release && (w_rsp_idx == IDX_W'(i));
            end
        end

        // Slot state; an issue and a release on the same slot cancel out
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_valid <= '0;
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    r_id[i]  <= '0;
                    r_cnt[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (w_inc[i] && !w_dec[i]) begin
                        r_valid[i] <= 1'b1;
                        r_id[i]    <= w_ax_sid[g];
                        r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
                    end else if (w_dec[i] && !w_inc[i]) begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                        if (r_cnt[i] == CNT_W'(1)) begin
                            r_valid[i] <= 1'b0;
                        end
                    end
                end
            end
        end

        // One-entry issue register toward the narrow-ID slave
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_full <= 1'b0;
                r_mid  <= '0;
                r_pl   <= '0;
            end else if (w_issue) begin
                r_full <= 1'b1;
                r_mid  <= OUT_ID_W'(w_sel_idx);
                r_pl   <= w_ax_spl[g];
            end else if (w_ax_mready[g]) begin
                r_full <= 1'b0;
            end
        end

        assign w_ax_full[g] = r_full;
        assign w_ax_mid[g]  = r_mid;
        assign w_ax_mpl[g]  = r_pl;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err <= 1'b0;
        end else if (|w_err_c) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_id_compressor.sv
// Scoreboard bench for axi4_id_compressor: stimulus queues expected outputs,
// negedge monitors pop and compare on every output handshake.
module tb_axi4_id_compressor;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          s_arvalid, s_arready, m_arvalid, m_arready;
    logic [15:0]   s_arid;
    logic [63:0]   s_ar_pl, m_ar_pl;
    logic [5:0]    m_arid;
    logic          s_awvalid, s_awready, m_awvalid, m_awready;
    logic [15:0]   s_awid;
    logic [63:0]   s_aw_pl, m_aw_pl;
    logic [5:0]    m_awid;
    logic          m_rvalid, m_rready, s_rvalid, s_rready;
    logic [5:0]    m_rid;
    logic [514:0]  m_r_pl, s_r_pl;
    logic [15:0]   s_rid;
    logic          m_bvalid, m_bready, s_bvalid, s_bready;
    logic [5:0]    m_bid;
    logic [1:0]    m_b_pl, s_b_pl;
    logic [15:0]   s_bid;
    logic          err_resp;

    typedef struct { logic [5:0]  id; logic [63:0]  pl; } ax_exp_t;
    typedef struct { logic [15:0] id; logic [514:0] pl; } r_exp_t;
    typedef struct { logic [15:0] id; logic [1:0]   pl; } b_exp_t;

    ax_exp_t exp_ar[$];
    ax_exp_t exp_aw[$];
    r_exp_t  exp_r[$];
    b_exp_t  exp_b[$];

    int errors = 0;
    int checks = 0;

    axi4_id_compressor dut (
        .CLK(CLK), .RST_N(RST_N),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_ar_pl(s_ar_pl),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_ar_pl(m_ar_pl),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_aw_pl(s_aw_pl),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_aw_pl(m_aw_pl),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_r_pl(m_r_pl),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_r_pl(s_r_pl),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_b_pl(m_b_pl),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_b_pl(s_b_pl),
        .err_resp(err_resp)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] ax_pl(input logic [15:0] id);
        return {16'hA5A5, id, 32'h0000_1000 + 32'(id)};
    endfunction

    function automatic logic [514:0] r_pl(input logic [5:0] mid, input logic last);
        logic [514:0] p;
        p        = '0;
        p[514:3] = {8{64'hC0FF_EE00_0000_0000 | 64'(mid)}};
        p[0]     = last;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // AR/AW request; returns at posedge+1 after the s-side handshake
    task automatic ax_send(input bit wr, input logic [15:0] id, input logic [5:0] mid);
        ax_exp_t e;
        int n;
        e.id = mid;
        e.pl = ax_pl(id);
        if (wr) begin
            s_awvalid = 1'b1; s_awid = id; s_aw_pl = e.pl; exp_aw.push_back(e);
        end else begin
            s_arvalid = 1'b1; s_arid = id; s_ar_pl = e.pl; exp_ar.push_back(e);
        end
        n = 0;
        @(negedge CLK);
        while (!(wr ? s_awready : s_arready) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(wr ? "aw_accept" : "ar_accept", 64'(wr ? s_awready : s_arready), 64'd1);
        tick();
        if (wr) s_awvalid = 1'b0; else s_arvalid = 1'b0;
    endtask

    // Drive one R/B beat for one cycle (upstream always ready)
    task automatic rsp_drive(input bit wr, input logic [5:0] mid, input logic last,
                             input logic [15:0] exp_sid);
        r_exp_t er;
        b_exp_t eb;
        if (wr) begin
            eb.id = exp_sid; eb.pl = mid[1:0];
            m_bvalid = 1'b1; m_bid = mid; m_b_pl = eb.pl; exp_b.push_back(eb);
        end else begin
            er.id = exp_sid; er.pl = r_pl(mid, last);
            m_rvalid = 1'b1; m_rid = mid; m_r_pl = er.pl; exp_r.push_back(er);
        end
    endtask

    task automatic rsp(input bit wr, input logic [5:0] mid, input logic last,
                       input logic [15:0] exp_sid);
        rsp_drive(wr, mid, last, exp_sid);
        tick();
        m_rvalid = 1'b0;
        m_bvalid = 1'b0;
    endtask

    // Monitors
    always @(negedge CLK) begin
        ax_exp_t e;
        if (RST_N && m_arvalid && m_arready) begin
            if (exp_ar.size() == 0) begin
                checks++; errors++;
                $display("FAIL ar_unexpected: got id %0h expected none", m_arid);
            end else begin
                e = exp_ar.pop_front();
                chk("m_arid", 64'(m_arid), 64'(e.id));
                chk("m_ar_pl", m_ar_pl, e.pl);
            end
        end
    end

    always @(negedge CLK) begin
        ax_exp_t e;
        if (RST_N && m_awvalid && m_awready) begin
            if (exp_aw.size() == 0) begin
                checks++; errors++;
                $display("FAIL aw_unexpected: got id %0h expected none", m_awid);
            end else begin
                e = exp_aw.pop_front();
                chk("m_awid", 64'(m_awid), 64'(e.id));
                chk("m_aw_pl", m_aw_pl, e.pl);
            end
        end
    end

    always @(negedge CLK) begin
        r_exp_t e;
        if (s_rvalid && s_rready) begin
            if (exp_r.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: got id %0h expected none", s_rid);
            end else begin
                e = exp_r.pop_front();
                chk("s_rid", 64'(s_rid), 64'(e.id));
                checks++;
                if (s_r_pl !== e.pl || !m_rready) begin
                    errors++;
                    $display("FAIL s_r_pl: got %0h expected %0h", s_r_pl[63:0], e.pl[63:0]);
                end
            end
        end
    end

    always @(negedge CLK) begin
        b_exp_t e;
        if (s_bvalid && s_bready) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got id %0h expected none", s_bid);
            end else begin
                e = exp_b.pop_front();
                chk("s_bid", 64'(s_bid), 64'(e.id));
                chk("s_b_pl", 64'(s_b_pl), 64'(e.pl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        s_arvalid = 0; s_arid = '0; s_ar_pl = '0; m_arready = 1'b1;
        s_awvalid = 0; s_awid = '0; s_aw_pl = '0; m_awready = 1'b1;
        m_rvalid = 0; m_rid = '0; m_r_pl = '0; s_rready = 1'b1;
        m_bvalid = 0; m_bid = '0; m_b_pl = '0; s_bready = 1'b1;
        #12;
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_err", 64'(err_resp), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // Single read with a 4-beat burst
        ax_send(0, 16'h1234, 6'd0);
        for (int i = 0; i < 4; i++) rsp(0, 6'd0, (i == 3), 16'h1234);

        // Same-ID stream reuses slot 0 (also shows slot 0 was freed)
        for (int i = 0; i < 3; i++) ax_send(0, 16'h00AA, 6'd0);
        rsp(0, 6'd0, 1'b1, 16'h00AA);
        rsp(0, 6'd0, 1'b1, 16'h00AA);
        ax_send(0, 16'h0BB0, 6'd1);
        rsp(0, 6'd0, 1'b1, 16'h00AA);
        ax_send(0, 16'h0CC0, 6'd0);
        rsp(0, 6'd0, 1'b1, 16'h0CC0);
        rsp(0, 6'd1, 1'b1, 16'h0BB0);

        // Table full, then release slot 5
        for (int i = 0; i < 8; i++) ax_send(0, 16'h0100 + 16'(i), 6'(i));
        s_arvalid = 1'b1; s_arid = 16'h01FF; s_ar_pl = ax_pl(16'h01FF);
        @(negedge CLK);
        chk("full_stall", 64'(s_arready), 64'd0);
        tick();
        rsp_drive(0, 6'd5, 1'b1, 16'h0105);
        @(negedge CLK);
        chk("full_stall_rel", 64'(s_arready), 64'd0);
        tick();
        m_rvalid = 1'b0;
        exp_ar.push_back('{id: 6'd5, pl: ax_pl(16'h01FF)});
        @(negedge CLK);
        chk("full_accept", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 1'b0;
        for (int i = 0; i < 8; i++)
            rsp(0, 6'(i), 1'b1, (i == 5) ? 16'h01FF : 16'h0100 + 16'(i));

        // Counter saturation at 15
        for (int i = 0; i < 15; i++) ax_send(0, 16'h0007, 6'd0);
        s_arvalid = 1'b1; s_arid = 16'h0007; s_ar_pl = ax_pl(16'h0007);
        @(negedge CLK);
        chk("sat_stall", 64'(s_arready), 64'd0);
        tick();
        rsp_drive(0, 6'd0, 1'b1, 16'h0007);
        @(negedge CLK);
        chk("sat_stall_rel", 64'(s_arready), 64'd0);
        tick();
        m_rvalid = 1'b0;
        exp_ar.push_back('{id: 6'd0, pl: ax_pl(16'h0007)});
        @(negedge CLK);
        chk("sat_accept", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 1'b0;
        for (int i = 0; i < 15; i++) rsp(0, 6'd0, 1'b1, 16'h0007);

        // Simultaneous AW issue and B release on the same slot
        ax_send(1, 16'h0055, 6'd0);
        s_awvalid = 1'b1; s_awid = 16'h0055; s_aw_pl = ax_pl(16'h0055);
        exp_aw.push_back('{id: 6'd0, pl: ax_pl(16'h0055)});
        rsp_drive(1, 6'd0, 1'b1, 16'h0055);
        @(negedge CLK);
        chk("sim_awready", 64'(s_awready), 64'd1);
        tick();
        s_awvalid = 1'b0;
        m_bvalid  = 1'b0;
        rsp(1, 6'd0, 1'b1, 16'h0055);
        ax_send(1, 16'h0066, 6'd0);
        rsp(1, 6'd0, 1'b1, 16'h0066);
        chk("sim_no_err", 64'(err_resp), 64'd0);

        // Downstream backpressure holds the issue register
        m_arready = 1'b0;
        ax_send(0, 16'h2222, 6'd0);
        s_arvalid = 1'b1; s_arid = 16'h3333; s_ar_pl = ax_pl(16'h3333);
        @(negedge CLK);
        chk("bp_arready", 64'(s_arready), 64'd0);
        chk("bp_arvalid", 64'(m_arvalid), 64'd1);
        chk("bp_arid", 64'(m_arid), 64'd0);
        chk("bp_pl", m_ar_pl, ax_pl(16'h2222));
        tick();
        m_arready = 1'b1;
        exp_ar.push_back('{id: 6'd1, pl: ax_pl(16'h3333)});
        @(negedge CLK);
        chk("bp_accept", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 1'b0;
        rsp(0, 6'd0, 1'b1, 16'h2222);
        rsp(0, 6'd1, 1'b1, 16'h3333);
        chk("pre_err", 64'(err_resp), 64'd0);

        // Out-of-range and unallocated response IDs
        rsp(0, 6'd9, 1'b1, 16'h0000);
        chk("err_oor", 64'(err_resp), 64'd1);
        rsp(0, 6'd3, 1'b0, 16'h0000);
        tick(); tick();
        chk("err_sticky", 64'(err_resp), 64'd1);
        ax_send(0, 16'h0ABC, 6'd0);
        rsp(0, 6'd0, 1'b1, 16'h0ABC);

        // Asynchronous reset with a request stuck in the issue register
        m_arready = 1'b0;
        ax_send(0, 16'h4444, 6'd0);
        chk("pre_rst_arvalid", 64'(m_arvalid), 64'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("async_rst_err", 64'(err_resp), 64'd0);
        exp_ar.delete();
        m_arready = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        rsp(0, 6'd0, 1'b1, 16'h0000);
        chk("stale_rsp_err", 64'(err_resp), 64'd1);

        tick(); tick();
        chk("q_ar_empty", 64'(exp_ar.size()), 64'd0);
        chk("q_aw_empty", 64'(exp_aw.size()), 64'd0);
        chk("q_r_empty", 64'(exp_r.size()), 64'd0);
        chk("q_b_empty", 64'(exp_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
